// File: rtl/sp_accum_module.sv
// Scratchpad of SP_NTARGETS small matrices (MAX_DIM rows each) with burst row writes,
// optional lane-wise accumulate, whole-target clear and a registered read port.
module sp_accum_module #(
    parameter  int SP_NTARGETS = 4,
    parameter  int DATA_WIDTH  = 32,
    parameter  int BUS_WIDTH   = 64,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int TW          = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int RW          = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // Write handshake: a beat transfers in any cycle where wr_valid_i & wr_ready_o.
    // wr_valid_i may drop between beats; the burst simply waits for the next beat.
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [TW-1:0]        wr_target_i,
    input  logic                 wr_accum_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    output logic                 wr_done_o,
    input  logic                 clr_i,
    input  logic [TW-1:0]        clr_target_i,
    input  logic                 rd_en_i,
    input  logic [TW-1:0]        rd_target_i,
    input  logic [RW-1:0]        rd_row_i,
    output logic [BUS_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [TW:0]   NT_LIM   = (TW+1)'(SP_NTARGETS);
    localparam logic [RW:0]   ROW_LIM  = (RW+1)'(MAX_DIM);
    localparam logic [RW-1:0] ROW_LAST = RW'(MAX_DIM - 1);

    logic [BUS_WIDTH-1:0] mem [SP_NTARGETS][MAX_DIM];

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [TW-1:0]        tgt_q, tgt_d;
    logic                 accum_q, accum_d;
    logic                 done_q, done_d;
    logic [BUS_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;

    logic                 mem_we;
    logic                 mem_zero;
    logic                 mem_accum;
    logic [TW-1:0]        mem_tgt;
    logic [RW-1:0]        mem_row;
    logic                 mem_tgt_ok;
    logic [BUS_WIDTH-1:0] cur_row;
    logic [BUS_WIDTH-1:0] sum_row;
    logic [BUS_WIDTH-1:0] new_row;
    logic                 rd_ok;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        tgt_d      = tgt_q;
        accum_d    = accum_q;
        done_d     = 1'b0;
        wr_ready_o = 1'b0;
        mem_we     = 1'b0;
        mem_zero   = 1'b0;
        mem_accum  = accum_q;
        mem_tgt    = tgt_q;
        mem_row    = row_q;
        case (state_q)
            ST_IDLE: begin
                // A clear request takes priority and blocks the write beat this cycle.
                wr_ready_o = ~clr_i;
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    tgt_d   = clr_target_i;
                    row_d   = '0;
                end else if (wr_valid_i) begin
                    mem_we    = 1'b1;
                    mem_tgt   = wr_target_i;
                    mem_row   = '0;
                    mem_accum = wr_accum_i;
                    tgt_d     = wr_target_i;
                    accum_d   = wr_accum_i;
                    if (MAX_DIM == 1) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        row_d   = RW'(1);
                    end
                end
            end
            ST_WRITE: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    mem_we = 1'b1;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_zero = 1'b1;
                if (row_q == ROW_LAST) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Out-of-range targets still run the full handshake but never touch storage.
    assign mem_tgt_ok = ({1'b0, mem_tgt} < NT_LIM);
    assign cur_row    = mem_tgt_ok ? mem[mem_tgt][mem_row] : '0;

    // Lane-wise add; each lane wraps on its own, carries never cross lanes.
    always_comb begin
        sum_row = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            sum_row[k*DATA_WIDTH +: DATA_WIDTH] = cur_row[k*DATA_WIDTH +: DATA_WIDTH]
                                                + wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign new_row = mem_zero ? '0 : (mem_accum ? sum_row : wr_data_i);
    assign rd_ok   = ({1'b0, rd_target_i} < NT_LIM) && ({1'b0, rd_row_i} < ROW_LIM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            tgt_q      <= '0;
            accum_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int t = 0; t < SP_NTARGETS; t++) begin
                for (int r = 0; r < MAX_DIM; r++) begin
                    mem[t][r] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            tgt_q      <= tgt_d;
            accum_q    <= accum_d;
            done_q     <= done_d;
            rd_valid_q <= rd_en_i;
            // Reads sample the array before this edge's write lands.
            if (rd_en_i) begin
                rd_data_q <= rd_ok ? mem[rd_target_i][rd_row_i] : '0;
            end
            if (mem_we && mem_tgt_ok) begin
                mem[mem_tgt][mem_row] <= new_row;
            end
        end
    end

    assign wr_done_o  = done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_sp_accum_module.sv
// Directed bench for sp_accum_module at 32-bit lanes, 64-bit rows, 4 targets.
module tb_sp_accum_module;

    localparam int DW = 32;
    localparam int BW = 64;
    localparam int NT = 4;
    localparam int TW = 2;
    localparam int RW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [TW-1:0] wr_target;
    logic          wr_accum;
    logic [BW-1:0] wr_data;
    logic          wr_done;
    logic          clr;
    logic [TW-1:0] clr_target;
    logic          rd_en;
    logic [TW-1:0] rd_target;
    logic [RW-1:0] rd_row;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] exp_q[$];

    sp_accum_module #(
        .SP_NTARGETS(NT),
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_target_i (wr_target),
        .wr_accum_i  (wr_accum),
        .wr_data_i   (wr_data),
        .wr_done_o   (wr_done),
        .clr_i       (clr),
        .clr_target_i(clr_target),
        .rd_en_i     (rd_en),
        .rd_target_i (rd_target),
        .rd_row_i    (rd_row),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .state_o     (state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [TW-1:0] t, input logic a,
                            input logic [BW-1:0] d);
        wr_valid  = v;
        wr_target = t;
        wr_accum  = a;
        wr_data   = d;
    endtask

    task automatic write_burst(input logic [TW-1:0] t, input logic a,
                               input logic [BW-1:0] d0, input logic [BW-1:0] d1);
        set_beat(1'b1, t, a, d0);
        step();
        set_beat(1'b1, t, a, d1);
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        step();
    endtask

    task automatic issue_read(input logic [TW-1:0] t, input logic [RW-1:0] r,
                              output logic v, output logic [BW-1:0] d);
        rd_en     = 1'b1;
        rd_target = t;
        rd_row    = r;
        step();
        rd_en = 1'b0;
        @(negedge clk);
        v = rd_valid;
        d = rd_data;
        step();
    endtask

    // Pops one expected row per read and compares; callers push in read order.
    task automatic read_rows(input logic [TW-1:0] t, input string name);
        logic          v;
        logic [BW-1:0] d;
        logic [BW-1:0] e;
        for (int r = 0; r < 2; r++) begin
            issue_read(t, RW'(r), v, d);
            e = exp_q.pop_front();
            checks++;
            if (v !== 1'b1 || d !== e) begin
                failures++;
                $display("FAIL %s rd(%0d,%0d): valid=%b data=%h, expected valid=1 data=%h",
                         name, t, r, v, d, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_beat(1'b0, '0, 1'b0, '0);
        clr = 1'b0; clr_target = '0;
        rd_en = 1'b0; rd_target = '0; rd_row = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: done=%b rd_valid=%b rd_data=%h busy=%b, expected all 0",
                     wr_done, rd_valid, rd_data, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || state !== 2'd0) begin
            failures++;
            $display("FAIL reset_release: wr_ready=%b state=%0d, expected 1 and 0", wr_ready, state);
        end
        step();
    endtask

    task automatic test_overwrite();
        set_beat(1'b1, 2'd2, 1'b0, 64'h00000002_00000001);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL ow_ready: wr_ready=%b, expected 1", wr_ready);
        end
        step();
        set_beat(1'b1, 2'd2, 1'b0, 64'h00000004_00000003);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_done !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL ow_mid: busy=%b done=%b state=%0d, expected 1 0 1", busy, wr_done, state);
        end
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ow_done: done=%b busy=%b, expected 1 0", wr_done, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b0) begin
            failures++;
            $display("FAIL ow_done_once: done=%b, expected 0", wr_done);
        end
        step();
        exp_q.push_back(64'h00000002_00000001);
        exp_q.push_back(64'h00000004_00000003);
        read_rows(2'd2, "overwrite");
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h00000004_00000003) begin
            failures++;
            $display("FAIL rd_hold: valid=%b data=%h, expected 0 and 0000000400000003",
                     rd_valid, rd_data);
        end
        step();
    endtask

    task automatic test_accumulate();
        write_burst(2'd1, 1'b0, 64'hFFFFFFFF_00000005, 64'h0);
        write_burst(2'd1, 1'b1, 64'h00000002_00000003, 64'h00000010_00000001);
        exp_q.push_back(64'h00000001_00000008);
        exp_q.push_back(64'h00000010_00000001);
        read_rows(2'd1, "accumulate");
    endtask

    task automatic test_stall();
        set_beat(1'b1, 2'd0, 1'b0, 64'h12345678_9ABCDEF0);
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || wr_done !== 1'b0) begin
                failures++;
                $display("FAIL stall_gap%0d: busy=%b done=%b, expected 1 0", i, busy, wr_done);
            end
            step();
        end
        set_beat(1'b1, 2'd3, 1'b1, 64'h0BADF00D_DEADBEEF);
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done: done=%b, expected 1", wr_done);
        end
        step();
        // Target and mode come from the first beat only.
        exp_q.push_back(64'h12345678_9ABCDEF0);
        exp_q.push_back(64'h0BADF00D_DEADBEEF);
        read_rows(2'd0, "stall");
    endtask

    task automatic test_clear_priority();
        write_burst(2'd3, 1'b0, 64'h33333333_33333333, 64'h44444444_44444444);
        clr = 1'b1;
        clr_target = 2'd3;
        set_beat(1'b1, 2'd0, 1'b0, 64'h00000000_000000AA);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_req_ready: wr_ready=%b, expected 0", wr_ready);
        end
        step();
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b0 || busy !== 1'b1 || state !== 2'd2) begin
                failures++;
                $display("FAIL clr_cycle%0d: wr_ready=%b busy=%b state=%0d, expected 0 1 2",
                         i, wr_ready, busy, state);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_end: wr_ready=%b busy=%b, expected 1 0", wr_ready, busy);
        end
        step();
        set_beat(1'b1, 2'd0, 1'b0, 64'h00000000_000000BB);
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        step();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        read_rows(2'd3, "clear_t3");
        exp_q.push_back(64'h00000000_000000AA);
        exp_q.push_back(64'h00000000_000000BB);
        read_rows(2'd0, "clear_wr_t0");
    endtask

    task automatic test_clr_ignored();
        set_beat(1'b1, 2'd1, 1'b0, 64'h01010101_01010101);
        step();
        clr = 1'b1;
        clr_target = 2'd1;
        set_beat(1'b1, 2'd1, 1'b0, 64'h02020202_02020202);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL clr_in_write: wr_ready=%b state=%0d, expected 1 1", wr_ready, state);
        end
        step();
        clr = 1'b0;
        set_beat(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_in_write_done: done=%b busy=%b, expected 1 0", wr_done, busy);
        end
        step();
        exp_q.push_back(64'h01010101_01010101);
        exp_q.push_back(64'h02020202_02020202);
        read_rows(2'd1, "clr_ignored");
    endtask

    task automatic test_reset_mid_burst();
        set_beat(1'b1, 2'd2, 1'b0, 64'h5A5A5A5A_5A5A5A5A);
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (wr_done !== 1'b0 || busy !== 1'b0 || state !== 2'd0) begin
                failures++;
                $display("FAIL rst_abort%0d: done=%b busy=%b state=%0d, expected 0 0 0",
                         i, wr_done, busy, state);
            end
            step();
        end
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        read_rows(2'd2, "rst_t2");
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        read_rows(2'd1, "rst_t1");
        set_beat(1'b1, 2'd2, 1'b0, 64'h11112222_33334444);
        step();
        set_beat(1'b1, 2'd2, 1'b0, 64'h55556666_77778888);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_newburst_mid: busy=%b done=%b, expected 1 0", busy, wr_done);
        end
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1) begin
            failures++;
            $display("FAIL rst_newburst_done: done=%b, expected 1", wr_done);
        end
        step();
        exp_q.push_back(64'h11112222_33334444);
        exp_q.push_back(64'h55556666_77778888);
        read_rows(2'd2, "rst_newburst");
    endtask

    task automatic test_read_during_write();
        set_beat(1'b1, 2'd0, 1'b0, 64'h00000000_00001111);
        step();
        set_beat(1'b1, 2'd0, 1'b0, 64'hAAAABBBB_CCCCDDDD);
        rd_en = 1'b1;
        rd_target = 2'd0;
        rd_row = 1'b1;
        step();
        set_beat(1'b0, '0, 1'b0, '0);
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h0 || wr_done !== 1'b1) begin
            failures++;
            $display("FAIL rdw_same_cycle: valid=%b data=%h done=%b, expected 1 0 1",
                     rd_valid, rd_data, wr_done);
        end
        step();
        exp_q.push_back(64'h00000000_00001111);
        exp_q.push_back(64'hAAAABBBB_CCCCDDDD);
        read_rows(2'd0, "rdw_after");
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_accumulate();
        test_stall();
        test_clear_priority();
        test_clr_ignored();
        test_reset_mid_burst();
        test_read_during_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_accum_module.md
SP_ACCUM_MODULE -- requirements
Module: sp_accum_module

Interface
REQ-001 SHALL have parameter SP_NTARGETS, default 4, the number of matrix targets held.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the element width in bits.
REQ-003 SHALL have parameter BUS_WIDTH, default 64, the row width in bits; MAX_DIM = BUS_WIDTH/DATA_WIDTH elements per row and rows per target (localparam).
REQ-004 SHALL use TW = max(1, $clog2(SP_NTARGETS)) and RW = max(1, $clog2(MAX_DIM)) as index widths.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 wr_valid_i  in  1  a write row beat is offered.
REQ-008 wr_ready_o  out  1  a beat is accepted when wr_valid_i & wr_ready_o.
REQ-009 wr_target_i  in  TW  target index; sampled on the first beat of a burst only.
REQ-010 wr_accum_i  in  1  1 = add the beat into stored row, 0 = overwrite; sampled on the first beat only.
REQ-011 wr_data_i  in  BUS_WIDTH  row data; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 wr_done_o  out  1  one-cycle pulse in the cycle after the final row of a burst is written.
REQ-013 clr_i  in  1  request to zero one whole target.
REQ-014 clr_target_i  in  TW  target to clear; sampled with clr_i.
REQ-015 rd_en_i  in  1  read request.
REQ-016 rd_target_i / rd_row_i  in  TW / RW  read address.
REQ-017 rd_data_o  out  BUS_WIDTH  registered read data.
REQ-018 rd_valid_o  out  1  rd_data_o is valid this cycle.
REQ-019 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-020 SHALL hold SP_NTARGETS*MAX_DIM rows of BUS_WIDTH bits; row address = target*MAX_DIM + row.
REQ-021 SHALL implement FSM states IDLE, WRITE, CLEAR.
REQ-022 IDLE: wr_ready_o=1; an accepted beat writes row 0, latches target and mode, and moves to WRITE (or stays IDLE with wr_done_o pulse if MAX_DIM=1).
REQ-023 WRITE: wr_ready_o=1; each accepted beat writes row counter value and increments it; the beat at row MAX_DIM-1 returns to IDLE, resets the counter, and schedules wr_done_o next cycle.
REQ-024 WRITE: cycles with wr_valid_i=0 SHALL hold state and counter (no timeout).
REQ-025 Accumulate mode: each lane stored = stored + incoming, modulo 2^DATA_WIDTH, no carry between lanes, no saturation.
REQ-026 IDLE with clr_i=1 SHALL move to CLEAR, zeroing one row of clr_target_i per cycle, rows 0..MAX_DIM-1, then return to IDLE; wr_ready_o=0 during CLEAR.
REQ-027 clr_i and wr_valid_i both high in IDLE: clear wins; the write beat is not accepted (wr_ready_o=0 that cycle).
REQ-028 clr_i outside IDLE SHALL be ignored.
REQ-029 Target index >= SP_NTARGETS: write beats are accepted and counted but discarded; clears are no-ops lasting MAX_DIM cycles; reads return zero.
REQ-030 Read: rd_en_i in cycle N gives rd_data_o and rd_valid_o=1 in cycle N+1; rd_valid_o=0 otherwise; rd_data_o holds its last value when rd_valid_o=0.
REQ-031 Reads are permitted in every state; a read of a row written or cleared in the same cycle SHALL return the pre-write contents.

Reset
REQ-032 rst_i=1 at a rising edge SHALL zero all memory rows, the row counter and the latched target/mode, and set state IDLE.
REQ-033 During and after reset: wr_done_o=0, rd_valid_o=0, rd_data_o=0, busy_o=0, wr_ready_o=1 once rst_i is low.
REQ-034 Reset mid-burst or mid-clear SHALL abort it; no wr_done_o pulse is emitted.

Verification (DATA_WIDTH=32, BUS_WIDTH=64, SP_NTARGETS=4)
REQ-035 Overwrite burst to target 2: rows 0x00000002_00000001, 0x00000004_00000003, then read (2,0),(2,1) -> same values one cycle after each rd_en_i; wr_done_o pulses once.
REQ-036 Accumulate: target 1 holds 0xFFFFFFFF_00000005; accumulate row 0 with 0x00000002_00000003 -> read 0x00000001_00000008 (lane wrap, no carry).
REQ-037 Stalled burst: beat 0, three idle cycles, beat 1 -> both rows written, busy_o high throughout the gap, wr_done_o after beat 1 only.
REQ-038 clr_i and wr_valid_i together in IDLE on target 3 -> wr_ready_o=0, target 3 reads zero, write beat accepted only after CLEAR ends (2 cycles).
REQ-039 Assert rst_i after first beat of a burst -> no wr_done_o, all rows read zero, next beat starts a new burst at row 0.
REQ-040 Read (0,1) in the same cycle as its write of 0xAAAA_BBBB_CCCC_DDDD over 0 -> returns 0; next read returns new value.
